inst_fetch: RTL

Producer side of the instruction register interface. It owns the PC and runs a request/acknowledge handshake with instruction memory. It delivers each fetched word on inst_out with a one-cycle ir_wr strobe, so the instruction register latches the word. It also accepts PC redirects (branch/jump) from the datapath, including redirects that arrive while a fetch is in flight.

---
 rtl/inst_fetch.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: producer side of the instruction register interface.
// Owns the PC, runs a req/ack handshake with instruction memory and hands
// each fetched word to the instruction register with a one-cycle ir_wr.
// PC redirects from the datapath are accepted in every state; a redirect
// that lands while a fetch is outstanding makes that fetch's data be dropped.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   fetch_en              fetch request, only looked at in IDLE
//   pc_ld, pc_ld_val      PC redirect strobe and target
//   imem_req, imem_addr   registered memory request / address
//   imem_ack, imem_rdata  memory data-valid pulse and read data
//   ir_wr, inst_out       IR write strobe and registered instruction word
//   pc, pc_plus4          current PC and combinational PC+4
//   busy                  high whenever the fetch FSM is not IDLE
//   misalign_err          sticky flag: fetch attempted from a misaligned PC
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        pc_ld,
  input  logic [31:0] pc_ld_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_wr,
  output logic [31:0] inst_out,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DELIVER} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic        r_imem_req, w_imem_req_next;
  logic [31:0] r_imem_addr, w_imem_addr_next;
  logic        r_ir_wr, w_ir_wr_next;
  logic [31:0] r_inst_out, w_inst_out_next;
  logic        r_misalign_err, w_misalign_err_next;
  // r_flush marks the outstanding fetch as stale; r_redir holds where the
  // PC must go once the memory finally acknowledges it.
  logic        r_flush, w_flush_next;
  logic [31:0] r_redir, w_redir_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_imem_req     <= 1'b0;
      r_imem_addr    <= 32'h0;
      r_ir_wr        <= 1'b0;
      r_inst_out     <= 32'h0;
      r_misalign_err <= 1'b0;
      r_flush        <= 1'b0;
      r_redir        <= 32'h0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_imem_req     <= w_imem_req_next;
      r_imem_addr    <= w_imem_addr_next;
      r_ir_wr        <= w_ir_wr_next;
      r_inst_out     <= w_inst_out_next;
      r_misalign_err <= w_misalign_err_next;
      r_flush        <= w_flush_next;
      r_redir        <= w_redir_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_imem_req_next     = r_imem_req;
    w_imem_addr_next    = r_imem_addr;
    w_ir_wr_next        = 1'b0;
    w_inst_out_next     = r_inst_out;
    w_misalign_err_next = r_misalign_err;
    w_flush_next        = r_flush;
    w_redir_next        = r_redir;

    case (r_state)
      S_IDLE: begin
        if (pc_ld) begin
          w_pc_next = pc_ld_val;
        end else if (fetch_en) begin
          if (r_pc[1:0] != 2'b00) begin
            w_misalign_err_next = 1'b1;
          end else begin
            w_imem_req_next  = 1'b1;
            w_imem_addr_next = r_pc;
            w_state_next     = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (imem_ack) begin
          w_imem_req_next = 1'b0;
          w_flush_next    = 1'b0;
          if (r_flush || pc_ld) begin
            // Stale fetch: drop the data and land on the newest redirect.
            w_pc_next    = pc_ld ? pc_ld_val : r_redir;
            w_state_next = S_IDLE;
          end else begin
            w_inst_out_next = imem_rdata;
            w_pc_next       = r_pc + 32'd4;
            w_ir_wr_next    = 1'b1;  // registered, so it is high for all of DELIVER
            w_state_next    = S_DELIVER;
          end
        end else if (pc_ld) begin
          w_flush_next = 1'b1;
          w_redir_next = pc_ld_val;
        end
      end

      S_DELIVER: begin
        w_state_next = S_IDLE;
        if (pc_ld) begin
          w_pc_next = pc_ld_val;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_imem_addr;
  assign ir_wr        = r_ir_wr;
  assign inst_out     = r_inst_out;
  assign pc           = r_pc;
  assign pc_plus4     = r_pc + 32'd4;
  assign busy         = (r_state != S_IDLE);
  assign misalign_err = r_misalign_err;

endmodule
